fir_decim_requant: RTL and testbench

//  Output stage downstream of the 3-tap FIR (16-bit sample each valid cycle). Decimates the filtered

---
 rtl/fir_decim_requant_if.sv | 28 ++
 rtl/fir_decim_requant.sv | 154 +++++++++++++++
 tb/tb_fir_decim_requant.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_requant_if.sv
// Valid/ready bundle between the FIR output stage and its surroundings.
// The slave modport is the decimator/requantiser side; the master modport
// is the side that supplies filtered samples and consumes results.
interface fir_decim_requant_if #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, fifo_level, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, fifo_level, overflow
    );
endinterface

// File: rtl/fir_decim_requant.sv
// FIR output stage: decimates the filtered stream by DECIM, requantises to
// OUT_W bits with round-half-up and unsigned saturation, and buffers the
// results in a first-word-fall-through FIFO toward the consumer.
// Optional feature macro: DECIM_AVG_EN -- when defined, each output is the
// boxcar sum of DECIM consecutive valid samples instead of the phase-0 sample.
module fir_decim_requant #(
    parameter int DECIM      = 4,
    parameter int SHIFT      = 2,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fir_decim_requant_if.slave bus
);
    localparam int PH_W  = $clog2(DECIM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

`ifdef DECIM_AVG_EN
    localparam int ACC_W     = IN_W + $clog2(DECIM);
    localparam int TOT_SHIFT = SHIFT + $clog2(DECIM);
`else
    localparam int ACC_W     = IN_W;
    localparam int TOT_SHIFT = SHIFT;
`endif

    localparam logic [ACC_W:0]   ROUND_ADD = (ACC_W+1)'(1) << (TOT_SHIFT - 1);
    localparam logic [ACC_W:0]   OUT_MAX   = (ACC_W+1)'((2**OUT_W) - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DECIM - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    // Round half up with one guard bit so the addition never wraps, then
    // clamp anything above the output range to all-ones.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] x);
        logic [ACC_W:0] r;
        r = ({1'b0, x} + ROUND_ADD) >> TOT_SHIFT;
        if (r > OUT_MAX) begin
            requant = OUT_MAX[OUT_W-1:0];
        end else begin
            requant = r[OUT_W-1:0];
        end
    endfunction

    logic [PH_W-1:0]  phase_q, phase_d;
    logic             stageValid_q, stageValid_d;
    logic [OUT_W-1:0] stageData_q, stageData_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [OUT_W-1:0] last_q, last_d;
    logic [OUT_W-1:0] mem_q [FIFO_DEPTH];

    logic             emit;
    logic [OUT_W-1:0] emitValue;
    logic             pop;
    logic             full;
    logic             pushOk;

`ifdef DECIM_AVG_EN
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sumNow;

    // Boxcar accumulator: restarts with the phase-0 sample and emits the
    // full group sum on the last phase of the group.
    always_comb begin
        sumNow    = (phase_q == '0) ? ACC_W'(bus.in_data) : acc_q + ACC_W'(bus.in_data);
        acc_d     = bus.in_valid ? sumNow : acc_q;
        emit      = bus.in_valid && (phase_q == PH_LAST);
        emitValue = requant(sumNow);
    end

    // Accumulator register, emptied on reset so a fresh group starts clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // Select mode: only the phase-0 sample of each group survives.
    always_comb begin
        emit      = bus.in_valid && (phase_q == '0);
        emitValue = requant(bus.in_data);
    end
`endif

    // Next-state for the phase counter, stage register and FIFO bookkeeping.
    // A full FIFO still accepts a push when the head is leaving that cycle.
    always_comb begin
        phase_d = phase_q;
        if (bus.in_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        stageValid_d = emit;
        stageData_d  = emit ? emitValue : stageData_q;

        pop    = (level_q != '0) && bus.out_ready;
        full   = (level_q == LVL_FULL);
        pushOk = stageValid_q && (!full || pop);

        rdPtr_d    = pop    ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        wrPtr_d    = pushOk ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        last_d     = pop    ? mem_q[rdPtr_q]      : last_q;
        overflow_d = overflow_q || (stageValid_q && full && !pop);

        level_d = level_q;
        if (pushOk && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !pushOk) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Control registers; reset discards the in-flight stage value and the
    // whole FIFO, and restarts the decimation phase at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q      <= '0;
            stageValid_q <= 1'b0;
            stageData_q  <= '0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            last_q       <= '0;
        end else begin
            phase_q      <= phase_d;
            stageValid_q <= stageValid_d;
            stageData_q  <= stageData_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            last_q       <= last_d;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && pushOk) begin
            mem_q[wrPtr_q] <= stageData_q;
        end
    end

    assign bus.out_valid  = (level_q != '0);
    assign bus.out_data   = (level_q != '0) ? mem_q[rdPtr_q] : last_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed testbench for fir_decim_requant with default parameters.
// Build with DECIM_AVG_EN defined to exercise the boxcar-average mode.
module tb_fir_decim_requant;
    localparam int DECIM      = 4;
    localparam int SHIFT      = 2;
    localparam int IN_W       = 16;
    localparam int OUT_W      = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun    = 0;
    int   testsFailed = 0;

    fir_decim_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    fir_decim_requant #(
        .DECIM(DECIM), .SHIFT(SHIFT), .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int d);
        bus.in_valid = v;
        bus.in_data  = IN_W'(d);
        tick();
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid);
        end
        testsRun++;
        if (bus.out_data !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_data: got %0d expected 0", bus.out_data);
        end
        testsRun++;
        if (bus.fifo_level !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_fifo_level: got %0d expected 0", bus.fifo_level);
        end
        testsRun++;
        if (bus.overflow !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_overflow: got %0b expected 0", bus.overflow);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_ramp();
        logic expValid;
        doReset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, i);
            expValid = ((i % 4) == 1);
            testsRun++;
            if (bus.out_valid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL ramp_valid[%0d]: got %0b expected %0b", i, bus.out_valid, expValid);
            end
            if (expValid) begin
                testsRun++;
                if (bus.out_data !== 8'((i - 1) / 4)) begin
                    testsFailed++;
                    $display("[TB] FAIL ramp_data[%0d]: got %0d expected %0d", i, bus.out_data, (i - 1) / 4);
                end
            end
            testsRun++;
            if (bus.fifo_level > 3'd1) begin
                testsFailed++;
                $display("[TB] FAIL ramp_level[%0d]: got %0d expected <=1", i, bus.fifo_level);
            end
        end
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
    endtask

    task automatic test_saturation();
        int samp [6] = '{1280, 65535, 1021, 1022, 1020, 1017};
        int expv [6] = '{255, 255, 255, 255, 255, 254};
        doReset();
        bus.out_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            applyStimulus(1'b1, samp[g]);
            applyStimulus(1'b1, 0);
            testsRun++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(expv[g])) begin
                testsFailed++;
                $display("[TB] FAIL sat[%0d] in=%0d: got valid=%0b data=%0d expected valid=1 data=%0d",
                         g, samp[g], bus.out_valid, bus.out_data, expv[g]);
            end
            applyStimulus(1'b1, 0);
            applyStimulus(1'b1, 0);
        end
    endtask

    task automatic test_backpressure();
        doReset();
        bus.out_ready = 1'b0;
        for (int g = 0; g < 6; g++) begin
            applyStimulus(1'b1, 4 * (g + 1));
            repeat (3) applyStimulus(1'b1, 0);
            if (g == 3) begin
                testsRun++;
                if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL bp_fill: got level=%0d ovf=%0b expected level=4 ovf=0",
                             bus.fifo_level, bus.overflow);
                end
            end
        end
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        testsRun++;
        if (bus.fifo_level !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL bp_level_full: got %0d expected 4", bus.fifo_level);
        end
        testsRun++;
        if (bus.overflow !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_overflow_set: got %0b expected 1", bus.overflow);
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            testsRun++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(j + 1)) begin
                testsFailed++;
                $display("[TB] FAIL bp_drain[%0d]: got valid=%0b data=%0d expected valid=1 data=%0d",
                         j, bus.out_valid, bus.out_data, j + 1);
            end
            applyStimulus(1'b0, 0);
        end
        testsRun++;
        if (bus.fifo_level !== 3'd0 || bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_empty: got level=%0d valid=%0b expected level=0 valid=0",
                     bus.fifo_level, bus.out_valid);
        end
        testsRun++;
        if (bus.overflow !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_overflow_sticky: got %0b expected 1", bus.overflow);
        end
        testsRun++;
        if (bus.out_data !== 8'd4) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold_last: got %0d expected 4", bus.out_data);
        end
    endtask

    task automatic test_full_pop();
        doReset();
        bus.out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            applyStimulus(1'b1, 4 * (g + 1));
            repeat (3) applyStimulus(1'b1, 0);
        end
        testsRun++;
        if (bus.fifo_level !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL fp_level_before: got %0d expected 4", bus.fifo_level);
        end
        applyStimulus(1'b1, 20);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 0);
        bus.out_ready = 1'b0;
        testsRun++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL fp_push_pop: got level=%0d ovf=%0b expected level=4 ovf=0",
                     bus.fifo_level, bus.overflow);
        end
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            testsRun++;
            if (bus.out_data !== 8'(j + 2)) begin
                testsFailed++;
                $display("[TB] FAIL fp_drain[%0d]: got %0d expected %0d", j, bus.out_data, j + 2);
            end
            applyStimulus(1'b0, 0);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 4);
        repeat (3) applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 8);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        testsRun++;
        if (bus.fifo_level !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL rm_level_before: got %0d expected 2", bus.fifo_level);
        end
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        testsRun++;
        if (bus.fifo_level !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL rm_cleared: got level=%0d valid=%0b data=%0d expected 0/0/0",
                     bus.fifo_level, bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 40);
        applyStimulus(1'b1, 0);
        testsRun++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd10) begin
            testsFailed++;
            $display("[TB] FAIL rm_first_kept: got valid=%0b data=%0d expected valid=1 data=10",
                     bus.out_valid, bus.out_data);
        end
        applyStimulus(1'b0, 0);
    endtask

`ifdef DECIM_AVG_EN
    task automatic test_avg();
        doReset();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 10);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b1, 40);
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL avg_early: got valid=%0b expected 0", bus.out_valid);
        end
        applyStimulus(1'b0, 0);
        testsRun++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd6) begin
            testsFailed++;
            $display("[TB] FAIL avg_mean: got valid=%0b data=%0d expected valid=1 data=6",
                     bus.out_valid, bus.out_data);
        end
        applyStimulus(1'b0, 0);
        repeat (4) applyStimulus(1'b1, 65535);
        applyStimulus(1'b0, 0);
        testsRun++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd255) begin
            testsFailed++;
            $display("[TB] FAIL avg_sat: got valid=%0b data=%0d expected valid=1 data=255",
                     bus.out_valid, bus.out_data);
        end
        applyStimulus(1'b0, 0);
    endtask
`endif

    // Runs every scenario in order and prints the single summary line.
    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
`ifdef DECIM_AVG_EN
        test_avg();
`else
        test_ramp();
        test_saturation();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
